// File: rtl/font_rd_arbiter_if.sv
// Font memory arbitration bundle: display fetch, secondary readback and memory ports.
// The slave modport is the arbiter's view, master is the requester/memory side.
interface font_rd_arbiter_if #(
   parameter int CHAR_W = 7,
   parameter int ROW_W  = 4,
   parameter int ADDR_W = 11
);
   logic              disp_req_i;
   logic [CHAR_W-1:0] disp_char_i;
   logic [ROW_W-1:0]  disp_row_i;
   logic              disp_valid_o;
   logic [7:0]        disp_data_o;
   logic              sec_req_i;
   logic [ADDR_W-1:0] sec_addr_i;
   logic              sec_gnt_o;
   logic              sec_rvalid_o;
   logic [7:0]        sec_rdata_o;
   logic              sec_starved_o;
   logic              clr_starved_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [7:0]        mem_dout_i;

   modport slave (
      input  disp_req_i, disp_char_i, disp_row_i,
      input  sec_req_i, sec_addr_i, clr_starved_i, mem_dout_i,
      output disp_valid_o, disp_data_o, sec_gnt_o, sec_rvalid_o,
      output sec_rdata_o, sec_starved_o, mem_addr_o
   );

   modport master (
      output disp_req_i, disp_char_i, disp_row_i,
      output sec_req_i, sec_addr_i, clr_starved_i, mem_dout_i,
      input  disp_valid_o, disp_data_o, sec_gnt_o, sec_rvalid_o,
      input  sec_rdata_o, sec_starved_o, mem_addr_o
   );
endinterface

// File: rtl/font_rd_arbiter.sv
// Font memory arbiter: display has strict priority, secondary gets idle cycles; read data
// returns 1 cycle after issue to the owning requester; secondary waits (held req) with starvation flag.
module font_rd_arbiter #(
   parameter int CHAR_W     = 7,
   parameter int ROW_W      = 4,
   parameter int ADDR_W     = 11,
   parameter int STARVE_MAX = 64
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   font_rd_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [ADDR_W-1:0] r_addr;
   logic              r_tag_disp;
   logic              r_tag_sec;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_starved;

   logic [ADDR_W-1:0] w_disp_addr;
   logic [ADDR_W-1:0] w_mem_addr;
   logic              w_sec_gnt;
   logic              w_wait;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_set;

   assign w_disp_addr = {bus.disp_char_i[CHAR_W-1:0], bus.disp_row_i[ROW_W-1:0]};
   assign w_sec_gnt   = bus.sec_req_i & ~bus.disp_req_i;
   assign w_wait      = bus.sec_req_i & ~w_sec_gnt;

   // Idle cycles replay the last issued address so the memory bus does not toggle.
   always_comb begin
      w_mem_addr = r_addr;
      if (bus.disp_req_i)
         w_mem_addr = w_disp_addr;
      else if (bus.sec_req_i)
         w_mem_addr = bus.sec_addr_i;
   end

   always_comb begin
      w_cnt_nxt = '0;
      if (w_wait)
         w_cnt_nxt = (r_wait_cnt == CNT_W'(STARVE_MAX)) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
   end

   assign w_set = w_wait & (w_cnt_nxt == CNT_W'(STARVE_MAX));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_addr     <= '0;
         r_tag_disp <= 1'b0;
         r_tag_sec  <= 1'b0;
         r_wait_cnt <= '0;
         r_starved  <= 1'b0;
      end else begin
         if (bus.disp_req_i | bus.sec_req_i)
            r_addr <= w_mem_addr;
         r_tag_disp <= bus.disp_req_i;
         r_tag_sec  <= w_sec_gnt;
         r_wait_cnt <= w_cnt_nxt;
         // A new set outranks a simultaneous clear so no starvation event is lost.
         r_starved  <= w_set | (r_starved & ~bus.clr_starved_i);
      end
   end

   assign bus.mem_addr_o    = w_mem_addr;
   assign bus.sec_gnt_o     = w_sec_gnt;
   assign bus.disp_valid_o  = r_tag_disp;
   assign bus.disp_data_o   = bus.mem_dout_i;
   assign bus.sec_rvalid_o  = r_tag_sec;
   assign bus.sec_rdata_o   = bus.mem_dout_i;
   assign bus.sec_starved_o = r_starved;
endmodule

// File: tb/tb_font_rd_arbiter.sv
// Self-checking bench for font_rd_arbiter: font memory model, issue-time scoreboard,
// per-cycle arbitration model and directed scenarios (stream, collision, starvation, reset).
module tb_font_rd_arbiter;
   localparam int CHAR_W     = 7;
   localparam int ROW_W      = 4;
   localparam int ADDR_W     = 11;
   localparam int STARVE_MAX = 64;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   font_rd_arbiter_if #(.CHAR_W(CHAR_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

   font_rd_arbiter #(
      .CHAR_W(CHAR_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
   ) u_dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   logic [7:0]        font [2048];
   logic [7:0]        q_disp [$];
   logic [7:0]        q_sec  [$];
   logic [ADDR_W-1:0] m_last;
   int                n_cmp = 0;
   int                n_err = 0;
   int                disp_run = 0;
   int                disp_run_max = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ADDR_W-1:0] disp_addr();
      return {bus.disp_char_i, bus.disp_row_i};
   endfunction

   // Font memory: one-cycle registered read.
   always @(posedge clk) bus.mem_dout_i <= font[bus.mem_addr_o];

   // Scoreboard push at issue time plus idle-address model.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_last <= '0;
         q_disp.delete();
         q_sec.delete();
      end else if (bus.disp_req_i) begin
         q_disp.push_back(font[disp_addr()]);
         m_last <= disp_addr();
      end else if (bus.sec_req_i) begin
         q_sec.push_back(font[bus.sec_addr_i]);
         m_last <= bus.sec_addr_i;
      end
   end

   // Per-cycle checks away from the active edge.
   always @(negedge clk) begin : mon
      logic [ADDR_W-1:0] ea;
      logic              eg;
      if (rstn) begin
         ea = m_last;
         eg = 1'b0;
         if (bus.disp_req_i) ea = disp_addr();
         else if (bus.sec_req_i) begin
            ea = bus.sec_addr_i;
            eg = 1'b1;
         end
         chk("mem_addr", 32'(bus.mem_addr_o), 32'(ea));
         chk("sec_gnt", 32'(bus.sec_gnt_o), 32'(eg));
         chk("disp_valid", 32'(bus.disp_valid_o), 32'(q_disp.size() != 0));
         if (bus.disp_valid_o && q_disp.size() != 0)
            chk("disp_data", 32'(bus.disp_data_o), 32'(q_disp.pop_front()));
         chk("sec_rvalid", 32'(bus.sec_rvalid_o), 32'(q_sec.size() != 0));
         if (bus.sec_rvalid_o && q_sec.size() != 0)
            chk("sec_rdata", 32'(bus.sec_rdata_o), 32'(q_sec.pop_front()));
         if (bus.disp_valid_o) disp_run++;
         else disp_run = 0;
         if (disp_run > disp_run_max) disp_run_max = disp_run;
      end
   end

   initial begin
      for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
      bus.disp_req_i    = 1'b0;
      bus.disp_char_i   = '0;
      bus.disp_row_i    = '0;
      bus.sec_req_i     = 1'b0;
      bus.sec_addr_i    = '0;
      bus.clr_starved_i = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_disp_valid", 32'(bus.disp_valid_o), 32'd0);
      chk("rst_sec_rvalid", 32'(bus.sec_rvalid_o), 32'd0);
      chk("rst_starved", 32'(bus.sec_starved_o), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
      rstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("idle_disp_valid", 32'(bus.disp_valid_o), 32'd0);
         chk("idle_sec_rvalid", 32'(bus.sec_rvalid_o), 32'd0);
         chk("idle_starved", 32'(bus.sec_starved_o), 32'd0);
         chk("idle_mem_addr", 32'(bus.mem_addr_o), 32'd0);
      end

      // Single display read of char 0x41 row 3.
      bus.disp_req_i  = 1'b1;
      bus.disp_char_i = 7'h41;
      bus.disp_row_i  = 4'd3;
      #1;
      chk("single_addr", 32'(bus.mem_addr_o), 32'h413);
      step();
      bus.disp_req_i = 1'b0;
      #1;
      chk("single_valid", 32'(bus.disp_valid_o), 32'd1);
      chk("single_data", 32'(bus.disp_data_o), 32'(font[1043]));
      chk("single_sec_quiet", 32'(bus.sec_rvalid_o), 32'd0);
      step();

      // Full sweep of every {char,row}, back to back.
      disp_run_max = 0;
      for (int i = 0; i < 2048; i++) begin
         bus.disp_req_i = 1'b1;
         {bus.disp_char_i, bus.disp_row_i} = 11'(i);
         step();
      end
      bus.disp_req_i = 1'b0;
      step();
      step();
      chk("stream_run", 32'(disp_run_max), 32'd2048);

      // Collision: display wins for 3 cycles, secondary granted in the 4th.
      bus.disp_req_i  = 1'b1;
      bus.disp_char_i = 7'h05;
      bus.disp_row_i  = 4'd9;
      bus.sec_req_i   = 1'b1;
      bus.sec_addr_i  = 11'h7FF;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("coll_gnt_low", 32'(bus.sec_gnt_o), 32'd0);
         step();
      end
      bus.disp_req_i = 1'b0;
      #1;
      chk("coll_gnt_high", 32'(bus.sec_gnt_o), 32'd1);
      step();
      bus.sec_req_i = 1'b0;
      #1;
      chk("coll_rvalid", 32'(bus.sec_rvalid_o), 32'd1);
      chk("coll_rdata", 32'(bus.sec_rdata_o), 32'(font[2047]));
      chk("coll_no_disp", 32'(bus.disp_valid_o), 32'd0);
      step();

      // Starvation: sticky flag after 64 waiting cycles.
      bus.disp_req_i  = 1'b1;
      bus.disp_char_i = 7'h22;
      bus.disp_row_i  = 4'd1;
      bus.sec_req_i   = 1'b1;
      bus.sec_addr_i  = 11'h123;
      for (int k = 1; k <= 70; k++) begin
         step();
         if (k == 63) chk("starve_before", 32'(bus.sec_starved_o), 32'd0);
         if (k == 64) chk("starve_set", 32'(bus.sec_starved_o), 32'd1);
      end
      bus.disp_req_i = 1'b0;
      #1;
      chk("starve_gnt", 32'(bus.sec_gnt_o), 32'd1);
      step();
      bus.sec_req_i = 1'b0;
      chk("starve_sticky", 32'(bus.sec_starved_o), 32'd1);
      step();
      chk("starve_sticky2", 32'(bus.sec_starved_o), 32'd1);
      bus.clr_starved_i = 1'b1;
      step();
      bus.clr_starved_i = 1'b0;
      chk("starve_cleared", 32'(bus.sec_starved_o), 32'd0);

      // Clear coinciding with a new set: set wins.
      bus.disp_req_i = 1'b1;
      bus.sec_req_i  = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         if (k == 64) bus.clr_starved_i = 1'b1;
         step();
         if (k == 63) chk("setwin_before", 32'(bus.sec_starved_o), 32'd0);
      end
      chk("setwin_flag", 32'(bus.sec_starved_o), 32'd1);
      bus.clr_starved_i = 1'b0;
      bus.disp_req_i    = 1'b0;
      step();
      bus.sec_req_i     = 1'b0;
      bus.clr_starved_i = 1'b1;
      step();
      bus.clr_starved_i = 1'b0;
      chk("setwin_cleared", 32'(bus.sec_starved_o), 32'd0);
      step();

      // Async reset with a display read in flight.
      bus.disp_req_i  = 1'b1;
      bus.disp_char_i = 7'h10;
      bus.disp_row_i  = 4'd2;
      step();
      bus.disp_req_i = 1'b0;
      #1;
      chk("rstmid_disp_pend", 32'(bus.disp_valid_o), 32'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("rstmid_disp_drop", 32'(bus.disp_valid_o), 32'd0);
      chk("rstmid_sec_quiet", 32'(bus.sec_rvalid_o), 32'd0);
      rstn = 1'b1;
      step();

      // Async reset with a secondary read in flight.
      bus.sec_req_i  = 1'b1;
      bus.sec_addr_i = 11'h055;
      step();
      bus.sec_req_i = 1'b0;
      #1;
      chk("rstmid_sec_pend", 32'(bus.sec_rvalid_o), 32'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("rstmid_sec_drop", 32'(bus.sec_rvalid_o), 32'd0);
      chk("rstmid_disp_quiet", 32'(bus.disp_valid_o), 32'd0);
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("post_rst_disp", 32'(bus.disp_valid_o), 32'd0);
         chk("post_rst_sec", 32'(bus.sec_rvalid_o), 32'd0);
      end

      chk("q_disp_left", 32'(q_disp.size()), 32'd0);
      chk("q_sec_left", 32'(q_sec.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
